pacman_motion_ctrl: RTL and testbench
=====================================

# pacman_motion_ctrl

Per-frame motion sequencer for Pac-Man. It holds the sprite position as cell index plus sub-cell offset, buffers the player's direction request, and queries the shared legal-moves lookup once per cell centre. It then commits a turn, a continuation, or a stop, and steps the position. It sits between the button debouncer and the sprite renderer, and it drives the cell-indexed port of the legal-moves table.

## Interface
- `START_COL`, default 3: reset column, 0..7
- `START_ROW`, default 6: reset row, 0..7
- `STEP`, default 2: pixels moved per tick; must divide `CELL` (60)
- `clk`  in  1: system clock
- `rst_n`  in  1: reset; one clock, synchronous, active-low
- `tick`  in  1: one-cycle frame strobe
- `btn_dir`  in  4: one-hot request; bit0 left, bit1 right, bit2 up, bit3 down
- `lk_req`  out  1: lookup strobe
- `lk_col`, `lk_row`  out  3 each: queried cell
- `lk_legal`  in  4: legal exits of the queried cell, same bit order as `btn_dir`; valid the cycle after `lk_req`
- `xpos`, `ypos`  out  10 each: sprite top-left pixel
- `cur_dir`  out  4: one-hot current heading; 0 means stopped
- `moved`  out  1: one-cycle pulse when the position changes
- `tick_drop`  out  1: one-cycle pulse when a tick arrives outside IDLE

## Operation
Position model:
- `xpos = 150 + col*60 + xoff`; `ypos = 34 + row*60 + yoff`. `xoff` and `yoff` range 0..59. At most one offset is nonzero at a time.
- The sprite is aligned when `xoff == 0` and `yoff == 0`. Legality is checked only when aligned.
- Stepping right or down: offset += `STEP`. When it reaches 60, the offset becomes 0 and `col` or `row` increments.
- Stepping left or up from offset 0: `col` or `row` decrements and the offset becomes 60 − `STEP`. Otherwise offset −= `STEP`.

Direction request buffer:
- `pend` is sampled every cycle. A valid one-hot `btn_dir` overwrites it.
- A `btn_dir` value of zero or multi-hot leaves `pend` unchanged.
- `pend` clears when adopted as `cur_dir`.

FSM:
- **IDLE**, on `tick`:
  - Not aligned, and `pend` is the opposite of `cur_dir`: adopt `pend` (reversal), go to MOVE.
  - Not aligned, otherwise: go to MOVE with `cur_dir`.
  - Aligned: go to REQ.
- **REQ**: `lk_req = 1`, `lk_col`/`lk_row` = current cell. Go to DECIDE.
- **DECIDE**: capture `lk_legal`.
  - If `pend != 0` and its bit is legal: adopt `pend`, go to MOVE.
  - Else if `cur_dir != 0` and its bit is legal: go to MOVE.
  - Else: `cur_dir` becomes 0, go to IDLE with no move.
- **MOVE**: apply one step in `cur_dir`, pulse `moved`, go to IDLE.

Boundary rules:
- An aligned move that would leave columns/rows 0..7 is treated as illegal, whatever `lk_legal` says.
- A `tick` in REQ, DECIDE or MOVE is dropped and pulses `tick_drop`; the FSM is unaffected.
- A `btn_dir` change in the same cycle as adoption: adoption uses the old `pend`, and the new value is then stored.
- Reset mid-sequence abandons the lookup. `lk_legal` is ignored until the next REQ.

## Timing
- Reset values: state IDLE, `col=START_COL`, `row=START_ROW`, offsets 0, `cur_dir=0`, `pend=0`, `lk_req=0`, `lk_col=lk_row=0`, `moved=0`, `tick_drop=0`.
- Aligned path (tick sampled at edge t):
  - `lk_req` high in cycle t+1.
  - `lk_legal` sampled in cycle t+2.
  - MOVE in cycle t+3.
  - New position and `moved` visible in cycle t+4.
- Unaligned path: MOVE in t+1; new position and `moved` in t+2.
- `lk_req` is high for exactly one cycle per aligned tick. Lookup latency is fixed at 1 cycle, and no backpressure exists.
- All outputs are registered. `xpos`/`ypos` are computed combinationally from registered col/row/offset.

## Structure
- Shared `pacman_pkg` holds:
  - direction constants `DIR_L=4'b0001`, `DIR_R=4'b0010`, `DIR_U=4'b0100`, `DIR_D=4'b1000`
  - `GRID_X0=150`, `GRID_Y0=34`, `CELL=60`, `GRID_N=8`
  - state encoding
  - an opposite-direction function
- Sub-module `motion_step`: combinational next col/row/offset from the current ones plus direction and `STEP`. Shared later with the ghost controllers.

## Test plan
- Reset, then release: `xpos=330`, `ypos=394`, `cur_dir=0`, `moved=0`; no `lk_req` before the first tick.
- Aligned at (3,6), `btn_dir=0010`, `lk_legal=0010`, tick at t: `lk_req` at t+1, `cur_dir=0010` at t+4, `xpos=332`, `moved` high for one cycle at t+4.
- Heading right with `xoff=58`, tick: `col=4`, `xoff=0`, `xpos=390`, with no `lk_req` issued.
- Aligned at (4,6), heading right, `pend=0100`, `lk_legal=0001`: neither requested nor current bit legal, so `cur_dir=0`, no `moved` pulse, position unchanged.
- Heading right with `xoff=20`, `btn_dir=0001`, tick: reversal without lookup; `cur_dir=0001`, `xoff=18`.
- Tick at t, second tick at t+2: `tick_drop` high at t+3 (one cycle after the dropped tick is sampled), only one `moved`. Aligned at col 0 heading left with `lk_legal=0001`: move blocked, `cur_dir=0`.

Source files
------------

// File: rtl/pacman_pkg.sv
// pacman_pkg: constants and helpers shared by the Pac-Man motion controller
// and, later, the ghost controllers.
//   - one-hot direction codes (bit0 left, bit1 right, bit2 up, bit3 down)
//   - playfield geometry (grid origin in pixels, cell size, grid size)
//   - motion FSM state encoding
//   - opposite_dir / is_one_hot helpers
package pacman_pkg;

  localparam logic [3:0] DIR_L = 4'b0001;
  localparam logic [3:0] DIR_R = 4'b0010;
  localparam logic [3:0] DIR_U = 4'b0100;
  localparam logic [3:0] DIR_D = 4'b1000;

  localparam int GRID_X0 = 150;
  localparam int GRID_Y0 = 34;
  localparam int CELL    = 60;
  localparam int GRID_N  = 8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_REQ    = 2'd1,
    ST_DECIDE = 2'd2,
    ST_MOVE   = 2'd3
  } state_t;

  // Reverse heading; anything that is not a single direction maps to "stopped".
  function automatic logic [3:0] opposite_dir(input logic [3:0] d);
    case (d)
      DIR_L:   return DIR_R;
      DIR_R:   return DIR_L;
      DIR_U:   return DIR_D;
      DIR_D:   return DIR_U;
      default: return 4'b0000;
    endcase
  endfunction

  function automatic logic is_one_hot(input logic [3:0] d);
    return (d != 4'b0000) && ((d & (d - 4'd1)) == 4'b0000);
  endfunction

endpackage

// File: rtl/pacman_motion_ctrl_step.sv
// motion_step: combinational single-step position update.
// Ports:
//   col, row        in  3  current cell
//   xoff, yoff      in  6  sub-cell offset, 0..CELL-1
//   dir             in  4  one-hot heading; zero or multi-hot holds position
//   nxt_col/nxt_row out 3  cell after one step
//   nxt_xoff/yoff   out 6  offset after one step
// Parameter STEP: pixels per step, must divide CELL.
module motion_step
  import pacman_pkg::*;
#(
  parameter int STEP = 2
) (
  input  logic [2:0] col,
  input  logic [2:0] row,
  input  logic [5:0] xoff,
  input  logic [5:0] yoff,
  input  logic [3:0] dir,
  output logic [2:0] nxt_col,
  output logic [2:0] nxt_row,
  output logic [5:0] nxt_xoff,
  output logic [5:0] nxt_yoff
);

  localparam logic [5:0] STEP_OFF = 6'(STEP);
  // Offset landed on when stepping backwards out of an aligned position.
  localparam logic [5:0] WRAP_OFF = 6'(CELL - STEP);
  localparam logic [6:0] CELL_7   = 7'(CELL);

  logic [6:0] xsum;
  logic [6:0] ysum;

  always_comb begin
    nxt_col  = col;
    nxt_row  = row;
    nxt_xoff = xoff;
    nxt_yoff = yoff;
    xsum     = {1'b0, xoff} + {1'b0, STEP_OFF};
    ysum     = {1'b0, yoff} + {1'b0, STEP_OFF};
    case (dir)
      DIR_R: begin
        if (xsum >= CELL_7) begin
          nxt_xoff = 6'd0;
          nxt_col  = col + 3'd1;
        end else begin
          nxt_xoff = xsum[5:0];
        end
      end
      DIR_L: begin
        if (xoff == 6'd0) begin
          nxt_xoff = WRAP_OFF;
          nxt_col  = col - 3'd1;
        end else begin
          nxt_xoff = xoff - STEP_OFF;
        end
      end
      DIR_D: begin
        if (ysum >= CELL_7) begin
          nxt_yoff = 6'd0;
          nxt_row  = row + 3'd1;
        end else begin
          nxt_yoff = ysum[5:0];
        end
      end
      DIR_U: begin
        if (yoff == 6'd0) begin
          nxt_yoff = WRAP_OFF;
          nxt_row  = row - 3'd1;
        end else begin
          nxt_yoff = yoff - STEP_OFF;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/pacman_motion_ctrl.sv
// pacman_motion_ctrl: per-frame Pac-Man motion sequencer.
// Holds position as cell + sub-cell offset, buffers the direction request,
// consults the legal-moves table once per cell centre and steps the sprite.
// Ports:
//   clk, rst_n        clock, synchronous active-low reset
//   tick              one-cycle frame strobe
//   btn_dir[3:0]      one-hot request (L,R,U,D = bit0..3)
//   lk_req            lookup strobe, one cycle per aligned tick
//   lk_col/lk_row     queried cell
//   lk_legal[3:0]     legal exits of queried cell
//   xpos/ypos[9:0]    sprite top-left pixel
//   cur_dir[3:0]      current heading, 0 = stopped
//   moved             pulse when position changes
//   tick_drop         pulse when a tick arrives while busy
//   dbg_state[1:0]    FSM state for observation
// Lookup handshake: lk_req is high for exactly one cycle with lk_col/lk_row
// stable; the table must present lk_legal in the following cycle, where it is
// sampled once. There is no ready/backpressure; lk_legal is ignored at all
// other times.
module pacman_motion_ctrl
  import pacman_pkg::*;
#(
  parameter int START_COL = 3,
  parameter int START_ROW = 6,
  parameter int STEP      = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic [3:0] btn_dir,
  output logic       lk_req,
  output logic [2:0] lk_col,
  output logic [2:0] lk_row,
  input  logic [3:0] lk_legal,
  output logic [9:0] xpos,
  output logic [9:0] ypos,
  output logic [3:0] cur_dir,
  output logic       moved,
  output logic       tick_drop,
  output logic [1:0] dbg_state
);

  state_t     state, state_nxt;
  logic [2:0] col, row;
  logic [5:0] xoff, yoff;
  logic [3:0] pend, pend_nxt, cur_dir_nxt;
  logic [3:0] edge_block, legal_eff;
  logic       aligned, adopt, start_req, do_step;
  logic [2:0] step_col, step_row;
  logic [5:0] step_xoff, step_yoff;

  motion_step #(.STEP(STEP)) u_step (
    .col      (col),
    .row      (row),
    .xoff     (xoff),
    .yoff     (yoff),
    .dir      (cur_dir),
    .nxt_col  (step_col),
    .nxt_row  (step_row),
    .nxt_xoff (step_xoff),
    .nxt_yoff (step_yoff)
  );

  assign aligned   = (xoff == 6'd0) && (yoff == 6'd0);
  assign xpos      = 10'(GRID_X0) + 10'(col) * 10'(CELL) + {4'b0000, xoff};
  assign ypos      = 10'(GRID_Y0) + 10'(row) * 10'(CELL) + {4'b0000, yoff};
  assign dbg_state = state;

  always_comb begin
    state_nxt   = state;
    cur_dir_nxt = cur_dir;
    adopt       = 1'b0;
    start_req   = 1'b0;
    do_step     = 1'b0;
    // Exits leaving the grid are blocked regardless of what the table says.
    edge_block  = 4'b0000;
    if (col == 3'd0)              edge_block = edge_block | DIR_L;
    if (col == 3'(GRID_N - 1))    edge_block = edge_block | DIR_R;
    if (row == 3'd0)              edge_block = edge_block | DIR_U;
    if (row == 3'(GRID_N - 1))    edge_block = edge_block | DIR_D;
    legal_eff   = lk_legal & ~edge_block;

    case (state)
      ST_IDLE: begin
        if (tick) begin
          if (aligned) begin
            start_req = 1'b1;
            state_nxt = ST_REQ;
          end else begin
            // Between cell centres only a reversal may change heading.
            if ((pend != 4'b0000) && (pend == opposite_dir(cur_dir))) begin
              cur_dir_nxt = pend;
              adopt       = 1'b1;
            end
            state_nxt = ST_MOVE;
          end
        end
      end
      ST_REQ: state_nxt = ST_DECIDE;
      ST_DECIDE: begin
        if ((pend != 4'b0000) && ((pend & legal_eff) != 4'b0000)) begin
          cur_dir_nxt = pend;
          adopt       = 1'b1;
          state_nxt   = ST_MOVE;
        end else if ((cur_dir != 4'b0000) && ((cur_dir & legal_eff) != 4'b0000)) begin
          state_nxt = ST_MOVE;
        end else begin
          cur_dir_nxt = 4'b0000;
          state_nxt   = ST_IDLE;
        end
      end
      ST_MOVE: begin
        do_step   = (cur_dir != 4'b0000);
        state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase

    // A new valid request wins over clearing on adoption: adoption already
    // consumed the old value this cycle.
    if (is_one_hot(btn_dir)) pend_nxt = btn_dir;
    else if (adopt)          pend_nxt = 4'b0000;
    else                     pend_nxt = pend;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      col       <= 3'(START_COL);
      row       <= 3'(START_ROW);
      xoff      <= 6'd0;
      yoff      <= 6'd0;
      cur_dir   <= 4'b0000;
      pend      <= 4'b0000;
      lk_req    <= 1'b0;
      lk_col    <= 3'd0;
      lk_row    <= 3'd0;
      moved     <= 1'b0;
      tick_drop <= 1'b0;
    end else begin
      cur_dir   <= cur_dir_nxt;
      pend      <= pend_nxt;
      lk_req    <= start_req;
      moved     <= do_step;
      tick_drop <= tick && (state != ST_IDLE);
      if (start_req) begin
        lk_col <= col;
        lk_row <= row;
      end
      if (do_step) begin
        col  <= step_col;
        row  <= step_row;
        xoff <= step_xoff;
        yoff <= step_yoff;
      end
    end
  end

endmodule

// File: tb/tb_pacman_motion_ctrl.sv
module tb_pacman_motion_ctrl;

  localparam int START_COL = 3;
  localparam int START_ROW = 6;
  localparam int STEP      = 2;
  localparam logic [3:0] L = 4'b0001;
  localparam logic [3:0] R = 4'b0010;
  localparam logic [3:0] U = 4'b0100;
  localparam logic [3:0] D = 4'b1000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic [3:0] btn_dir = 4'b0000;
  logic       lk_req;
  logic [2:0] lk_col, lk_row;
  logic [3:0] lk_legal = 4'b0000;
  logic [9:0] xpos, ypos;
  logic [3:0] cur_dir;
  logic       moved, tick_drop;
  logic [1:0] dbg_state;

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  pacman_motion_ctrl #(.START_COL(START_COL), .START_ROW(START_ROW), .STEP(STEP)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .tick      (tick),
    .btn_dir   (btn_dir),
    .lk_req    (lk_req),
    .lk_col    (lk_col),
    .lk_row    (lk_row),
    .lk_legal  (lk_legal),
    .xpos      (xpos),
    .ypos      (ypos),
    .cur_dir   (cur_dir),
    .moved     (moved),
    .tick_drop (tick_drop),
    .dbg_state (dbg_state)
  );

  int n_cmp = 0;
  int n_fail = 0;

  // legal-moves table the bench serves on the lookup port: tbl[row][col]
  logic [3:0] tbl [8][8];

  // ---------------- reference model (absolute pixel space) ----------------
  int         m_px, m_py;
  logic [3:0] m_cur, m_pend;
  bit         e_req, e_mv;
  int         e_col, e_row;
  logic [9:0] exp_q[$];

  // observations of the last frame
  int o_req_cnt, o_req_idx, o_col, o_row, o_mv_cnt, o_mv_idx, o_drop_cnt, o_drop_idx;

  function automatic logic [3:0] opp(input logic [3:0] d);
    if (d == L) return R;
    if (d == R) return L;
    if (d == U) return D;
    if (d == D) return U;
    return 4'b0000;
  endfunction

  function automatic bit exit_ok(input logic [3:0] d, input int c, input int r);
    int nc, nr;
    nc = c; nr = r;
    if (d == L) nc = c - 1;
    if (d == R) nc = c + 1;
    if (d == U) nr = r - 1;
    if (d == D) nr = r + 1;
    if ((tbl[r][c] & d) == 4'b0000) return 1'b0;
    return (nc >= 0) && (nc < 8) && (nr >= 0) && (nr < 8);
  endfunction

  function automatic bit m_aligned();
    return ((m_px - 150) % 60 == 0) && ((m_py - 34) % 60 == 0);
  endfunction

  task automatic model_reset();
    m_px = 150 + START_COL * 60;
    m_py = 34 + START_ROW * 60;
    m_cur = 4'b0000;
    m_pend = 4'b0000;
  endtask

  task automatic model_press(input logic [3:0] b);
    if ($countones(b) == 1) m_pend = b;
  endtask

  task automatic model_frame();
    int c, r;
    c = (m_px - 150) / 60;
    r = (m_py - 34) / 60;
    e_req = 1'b0; e_mv = 1'b0; e_col = -1; e_row = -1;
    if (!m_aligned()) begin
      if (m_pend != 4'b0000 && m_pend == opp(m_cur)) begin
        m_cur = m_pend; m_pend = 4'b0000;
      end
      e_mv = (m_cur != 4'b0000);
    end else begin
      e_req = 1'b1; e_col = c; e_row = r;
      if (m_pend != 4'b0000 && exit_ok(m_pend, c, r)) begin
        m_cur = m_pend; m_pend = 4'b0000; e_mv = 1'b1;
      end else if (m_cur != 4'b0000 && exit_ok(m_cur, c, r)) begin
        e_mv = 1'b1;
      end else begin
        m_cur = 4'b0000;
      end
    end
    if (e_mv) begin
      if (m_cur == L) m_px -= STEP;
      if (m_cur == R) m_px += STEP;
      if (m_cur == U) m_py -= STEP;
      if (m_cur == D) m_py += STEP;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; tick = 1'b0; btn_dir = 4'b0000; lk_legal = 4'($urandom);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic press(input logic [3:0] b);
    @(negedge clk);
    btn_dir = b;
    @(negedge clk);
    btn_dir = 4'b0000;
    model_press(b);
  endtask

  // One frame: tick (with btn b in the same cycle), optional second tick
  // sampled drop_at+1 edges later, lookup table served in the cycle after
  // lk_req, everything else on lk_legal is noise.
  task automatic run_frame(input logic [3:0] b, input int drop_at);
    bit prev_req;
    if (m_aligned()) begin
      model_press(b); model_frame();
    end else begin
      model_frame(); model_press(b);
    end
    @(negedge clk);
    tick = 1'b1; btn_dir = b; lk_legal = 4'($urandom);
    o_req_cnt = 0; o_req_idx = -1; o_col = -1; o_row = -1;
    o_mv_cnt = 0; o_mv_idx = -1; o_drop_cnt = 0; o_drop_idx = -1;
    prev_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (lk_req === 1'b1) begin
        o_req_cnt++; o_req_idx = i; o_col = int'(lk_col); o_row = int'(lk_row);
      end
      if (moved === 1'b1) begin o_mv_cnt++; o_mv_idx = i; end
      if (tick_drop === 1'b1) begin o_drop_cnt++; o_drop_idx = i; end
      tick = (i == drop_at);
      btn_dir = 4'b0000;
      if (prev_req && o_col >= 0 && o_row >= 0) lk_legal = tbl[o_row][o_col];
      else lk_legal = 4'($urandom);
      prev_req = (lk_req === 1'b1);
    end
    tick = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int reqs;
    do_reset();
    n_cmp++; if (xpos !== 10'd330) begin n_fail++; $display("FAIL reset_xpos: got %0d expected 330", xpos); end
    n_cmp++; if (ypos !== 10'd394) begin n_fail++; $display("FAIL reset_ypos: got %0d expected 394", ypos); end
    n_cmp++; if (cur_dir !== 4'b0000) begin n_fail++; $display("FAIL reset_cur_dir: got %b expected 0000", cur_dir); end
    n_cmp++; if ({moved, tick_drop, lk_req} !== 3'b000) begin n_fail++; $display("FAIL reset_pulses: got %b expected 000", {moved, tick_drop, lk_req}); end
    n_cmp++; if ({lk_col, lk_row} !== 6'd0) begin n_fail++; $display("FAIL reset_lk_cell: got %0d,%0d expected 0,0", lk_col, lk_row); end
    reqs = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      lk_legal = 4'($urandom);
      if (lk_req !== 1'b0) reqs++;
    end
    n_cmp++; if (reqs != 0) begin n_fail++; $display("FAIL reset_no_req: got %0d requests expected 0", reqs); end
  endtask

  task automatic test_reset_mid();
    int seen;
    @(negedge clk); tick = 1'b1;
    @(negedge clk); tick = 1'b0;
    n_cmp++; if (lk_req !== 1'b1) begin n_fail++; $display("FAIL mid_req: got %b expected 1", lk_req); end
    rst_n = 1'b0; lk_legal = 4'b1111;
    @(negedge clk); rst_n = 1'b1;
    model_reset();
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (lk_req !== 1'b0 || moved !== 1'b0) seen++;
    end
    n_cmp++; if (seen != 0) begin n_fail++; $display("FAIL mid_abandon: got %0d active cycles expected 0", seen); end
    n_cmp++; if (xpos !== 10'd330 || cur_dir !== 4'b0000) begin n_fail++; $display("FAIL mid_state: got x=%0d dir=%b expected x=330 dir=0000", xpos, cur_dir); end
    lk_legal = 4'b0000;
  endtask

  task automatic test_aligned_turn();
    tbl[6][3] = R;
    press(R);
    run_frame(4'b0000, -1);
    n_cmp++; if (o_req_idx != 0 || o_req_cnt != 1) begin n_fail++; $display("FAIL turn_req: got idx %0d cnt %0d expected idx 0 cnt 1", o_req_idx, o_req_cnt); end
    n_cmp++; if (o_col != 3 || o_row != 6) begin n_fail++; $display("FAIL turn_cell: got %0d,%0d expected 3,6", o_col, o_row); end
    n_cmp++; if (o_mv_idx != 3 || o_mv_cnt != 1) begin n_fail++; $display("FAIL turn_moved: got idx %0d cnt %0d expected idx 3 cnt 1", o_mv_idx, o_mv_cnt); end
    n_cmp++; if (xpos !== 10'd332 || xpos !== 10'(m_px)) begin n_fail++; $display("FAIL turn_xpos: got %0d expected 332", xpos); end
    n_cmp++; if (cur_dir !== R) begin n_fail++; $display("FAIL turn_dir: got %b expected 0010", cur_dir); end
  endtask

  task automatic test_cell_cross();
    for (int g = 0; g < 100 && m_px != 388; g++) run_frame(4'b0000, -1);
    n_cmp++; if (xpos !== 10'd388) begin n_fail++; $display("FAIL cross_pre: got %0d expected 388", xpos); end
    run_frame(4'b0000, -1);
    n_cmp++; if (xpos !== 10'd390 || ypos !== 10'd394) begin n_fail++; $display("FAIL cross_pos: got %0d,%0d expected 390,394", xpos, ypos); end
    n_cmp++; if (o_req_cnt != 0) begin n_fail++; $display("FAIL cross_no_req: got %0d expected 0", o_req_cnt); end
    n_cmp++; if (o_mv_idx != 1) begin n_fail++; $display("FAIL cross_latency: got %0d expected 1", o_mv_idx); end
  endtask

  task automatic test_stop();
    press(U);
    tbl[6][4] = L;
    run_frame(4'b0000, -1);
    n_cmp++; if (o_req_cnt != 1 || o_col != 4) begin n_fail++; $display("FAIL stop_req: got cnt %0d col %0d expected 1,4", o_req_cnt, o_col); end
    n_cmp++; if (cur_dir !== 4'b0000) begin n_fail++; $display("FAIL stop_dir: got %b expected 0000", cur_dir); end
    n_cmp++; if (o_mv_cnt != 0 || xpos !== 10'd390 || ypos !== 10'd394) begin n_fail++; $display("FAIL stop_pos: got mv %0d pos %0d,%0d expected 0 390,394", o_mv_cnt, xpos, ypos); end
  endtask

  task automatic test_reversal();
    press(R);
    tbl[6][4] = R;
    run_frame(4'b0000, -1);
    for (int g = 0; g < 100 && m_px != 410; g++) run_frame(4'b0000, -1);
    n_cmp++; if (xpos !== 10'd410) begin n_fail++; $display("FAIL rev_pre: got %0d expected 410", xpos); end
    press(L);
    run_frame(4'b0000, -1);
    n_cmp++; if (cur_dir !== L) begin n_fail++; $display("FAIL rev_dir: got %b expected 0001", cur_dir); end
    n_cmp++; if (xpos !== 10'd408 || o_req_cnt != 0) begin n_fail++; $display("FAIL rev_pos: got %0d req %0d expected 408 req 0", xpos, o_req_cnt); end
  endtask

  task automatic test_tick_drop();
    for (int g = 0; g < 100 && m_px != 390; g++) run_frame(4'b0000, -1);
    tbl[6][4] = L;
    run_frame(4'b0000, 1);
    n_cmp++; if (o_drop_cnt != 1 || o_drop_idx != 2) begin n_fail++; $display("FAIL drop_pulse: got cnt %0d idx %0d expected 1,2", o_drop_cnt, o_drop_idx); end
    n_cmp++; if (o_mv_cnt != 1 || o_mv_idx != 3) begin n_fail++; $display("FAIL drop_moved: got cnt %0d idx %0d expected 1,3", o_mv_cnt, o_mv_idx); end
    n_cmp++; if (xpos !== 10'd388) begin n_fail++; $display("FAIL drop_pos: got %0d expected 388", xpos); end
  endtask

  task automatic test_edge_block();
    for (int c = 0; c < 8; c++) tbl[6][c] = L;
    for (int g = 0; g < 200 && m_px != 150; g++) run_frame(4'b0000, -1);
    n_cmp++; if (xpos !== 10'd150 || cur_dir !== L) begin n_fail++; $display("FAIL edge_pre: got %0d dir %b expected 150 dir 0001", xpos, cur_dir); end
    run_frame(4'b0000, -1);
    n_cmp++; if (o_req_cnt != 1 || o_col != 0 || o_row != 6) begin n_fail++; $display("FAIL edge_req: got cnt %0d cell %0d,%0d expected 1 0,6", o_req_cnt, o_col, o_row); end
    n_cmp++; if (cur_dir !== 4'b0000 || o_mv_cnt != 0 || xpos !== 10'd150) begin n_fail++; $display("FAIL edge_block: got dir %b mv %0d x %0d expected 0000 0 150", cur_dir, o_mv_cnt, xpos); end
  endtask

  task automatic test_same_cycle();
    tbl[6][0] = R;
    press(R);
    run_frame(4'b0000, -1);
    press(L);
    run_frame(U, -1);
    n_cmp++; if (cur_dir !== L || xpos !== 10'd150) begin n_fail++; $display("FAIL same_adopt: got dir %b x %0d expected 0001 150", cur_dir, xpos); end
    tbl[6][0] = 4'b0101;
    run_frame(4'b0000, -1);
    n_cmp++; if (cur_dir !== U || ypos !== 10'd392 || xpos !== 10'd150) begin n_fail++; $display("FAIL same_stored: got dir %b pos %0d,%0d expected 0100 150,392", cur_dir, xpos, ypos); end
  endtask

  task automatic test_random();
    logic [3:0] b;
    logic [9:0] ex;
    do_reset();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        tbl[r][c] = 4'($urandom) | (4'b0001 << $urandom_range(0, 3));
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 2) == 0) press(4'($urandom));
      b = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      run_frame(b, -1);
      exp_q.push_back(10'(m_px));
      ex = exp_q.pop_front();
      n_cmp++; if (o_req_cnt != int'(e_req) || (e_req && (o_col != e_col || o_row != e_row))) begin
        n_fail++; $display("FAIL rnd_req[%0d]: got cnt %0d cell %0d,%0d expected cnt %0d cell %0d,%0d", n, o_req_cnt, o_col, o_row, e_req, e_col, e_row);
      end
      n_cmp++; if (o_mv_cnt != int'(e_mv) || (e_mv && o_mv_idx != (e_req ? 3 : 1))) begin
        n_fail++; $display("FAIL rnd_moved[%0d]: got cnt %0d idx %0d expected cnt %0d", n, o_mv_cnt, o_mv_idx, e_mv);
      end
      n_cmp++; if (xpos !== ex || ypos !== 10'(m_py)) begin
        n_fail++; $display("FAIL rnd_pos[%0d]: got %0d,%0d expected %0d,%0d", n, xpos, ypos, ex, m_py);
      end
      n_cmp++; if (cur_dir !== m_cur || o_drop_cnt != 0) begin
        n_fail++; $display("FAIL rnd_dir[%0d]: got %b drop %0d expected %b drop 0", n, cur_dir, o_drop_cnt, m_cur);
      end
    end
  endtask

  // ---------------- sequence + report ----------------
  initial begin
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        tbl[r][c] = 4'b0000;
    model_reset();
    test_reset();
    test_reset_mid();
    test_aligned_turn();
    test_cell_cross();
    test_stop();
    test_reversal();
    test_tick_drop();
    test_edge_block();
    test_same_cycle();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
